serv_dbg_decode: RTL and testbench

Debug-aware instruction front-end between the ibus and the SERV decoder. Buffers fetched words in a parametrised-depth queue, presents the head instruction to downstream decode, and owns the debug-mode state machine. That state machine handles halt request, ebreak, dret and single-step by injecting a synthetic ebreak in place of the head instruction.

---
 rtl/serv_dbg_decode_if.sv | 22 ++
 rtl/serv_dbg_decode.sv | 173 +++++++++++++++++
 tb/tb_serv_dbg_decode.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/serv_dbg_decode_if.sv
// Fetch/decode handshake bundle: ibus push side plus the decode-facing head instruction.
// master = fetch/core side driving words and retire strobes; slave = serv_dbg_decode.
interface serv_dbg_decode_if;
  logic [31:0] i_wb_rdt;
  logic        i_wb_en;
  logic        o_ibus_ready;
  logic        i_flush;
  logic        i_cnt_done;
  logic        o_valid;
  logic [31:0] o_insn;
  logic        o_inject;

  modport master (
    output i_wb_rdt, i_wb_en, i_flush, i_cnt_done,
    input  o_ibus_ready, o_valid, o_insn, o_inject
  );

  modport slave (
    input  i_wb_rdt, i_wb_en, i_flush, i_cnt_done,
    output o_ibus_ready, o_valid, o_insn, o_inject
  );
endinterface

// File: rtl/serv_dbg_decode.sv
// Debug-aware instruction queue + debug-mode FSM; SERV_DBG_STEP_EN adds single-step (STEP state).
// Push->o_valid in 1 cycle; o_ibus_ready low while full (extra words dropped); head held until i_cnt_done.
module serv_dbg_decode #(
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 i_rst,
  serv_dbg_decode_if.slave     bus,
  input  logic                 i_dbg_halt,
  input  logic                 i_dbg_step,
  output logic                 o_dbg_mode,
  output logic [2:0]           o_dbg_cause
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
  localparam logic [31:0]   EBREAK = 32'h0010_0073;
  localparam logic [31:0]   DRET   = 32'h7b20_0073;

  typedef enum logic [1:0] {
    S_RUN,
    S_ENTER,
    S_DEBUG
`ifdef SERV_DBG_STEP_EN
    , S_STEP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  cause_q, cause_d;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        halt_s;
  logic        not_empty;
  logic        inject;
  logic        push;
  logic        pop;
  logic        retire;
  logic [31:0] head;

  // Halt request arrives from another clock domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign halt_s = i_dbg_halt;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (i_rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= i_dbg_halt;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign halt_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

`ifndef SERV_DBG_STEP_EN
  logic unused_step;
  assign unused_step = i_dbg_step;
`endif

  assign not_empty = (count_q != '0);
  assign inject    = (state_q == S_ENTER);
  assign head      = mem_q[rd_ptr_q];
  // The injected ebreak never consumes a queue entry.
  assign push      = bus.i_wb_en & bus.o_ibus_ready & ~bus.i_flush;
  assign pop       = bus.i_cnt_done & bus.o_valid & ~inject;
  assign retire    = bus.i_cnt_done & not_empty;

  assign bus.o_ibus_ready = (count_q != FULL);
  assign bus.o_valid      = not_empty | inject;
  assign bus.o_inject     = inject;
  assign bus.o_insn       = inject ? EBREAK : (not_empty ? head : '0);
  assign o_dbg_mode       = (state_q == S_DEBUG);
  assign o_dbg_cause      = cause_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_wb_rdt;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cause_d = cause_q;
    case (state_q)
      S_RUN: begin
        if (retire && head == EBREAK) begin
          state_d = S_DEBUG;
          cause_d = 3'd1;
        end else if (halt_s && (!not_empty || bus.i_cnt_done)) begin
          state_d = S_ENTER;
          pend_d  = 3'd3;
        end
      end
      S_ENTER: begin
        if (bus.i_cnt_done) begin
          state_d = S_DEBUG;
          cause_d = pend_q;
        end
      end
      S_DEBUG: begin
        if (retire && head == DRET) begin
`ifdef SERV_DBG_STEP_EN
          state_d = i_dbg_step ? S_STEP : S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
`ifdef SERV_DBG_STEP_EN
      S_STEP: begin
        // A pending halt outranks the step as the recorded cause.
        if (retire) begin
          state_d = S_ENTER;
          pend_d  = halt_s ? 3'd3 : 3'd4;
        end else if (halt_s && !not_empty) begin
          state_d = S_ENTER;
          pend_d  = 3'd3;
        end
      end
`endif
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= S_RUN;
      pend_q   <= '0;
      cause_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cause_q  <= cause_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_serv_dbg_decode.sv
// Bench for serv_dbg_decode: vector table for queue behaviour, scoreboard stream, debug-mode sequences.
module tb_serv_dbg_decode;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] DRET   = 32'h7b20_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI1  = 32'h0010_0093;
  localparam logic [31:0] ADDI5  = 32'h0050_0293;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt;
  logic       step;
  logic       dbg_mode;
  logic [2:0] cause;

  always #5 clk = ~clk;

  serv_dbg_decode_if bus();

  serv_dbg_decode #(.DEPTH(2), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .i_rst       (rst),
    .bus         (bus),
    .i_dbg_halt  (halt),
    .i_dbg_step  (step),
    .o_dbg_mode  (dbg_mode),
    .o_dbg_cause (cause)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wb_en;
    logic [31:0] rdt;
    logic        done;
    logic        flush;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_insn;
  } vec_t;

  vec_t        vt [11];
  logic [31:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wb_en    = 1'b0;
    bus.i_wb_rdt   = '0;
    bus.i_cnt_done = 1'b0;
    bus.i_flush    = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    bus.i_wb_en  = 1'b1;
    bus.i_wb_rdt = w;
    tick();
    idle();
  endtask

  task automatic retire();
    bus.i_cnt_done = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst  = 1'b1;
    halt = 1'b0;
    step = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},  bus.o_ibus_ready, 1);
    chk({tag, "_valid"},  bus.o_valid, 0);
    chk({tag, "_insn"},   bus.o_insn, 0);
    chk({tag, "_inject"}, bus.o_inject, 0);
    chk({tag, "_mode"},   dbg_mode, 0);
    chk({tag, "_cause"},  cause, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    int          guard;
    logic [31:0] w;

    // Outputs listed are those seen after the edge that consumes the inputs.
    vt[0]  = '{1'b1, NOP,           1'b0, 1'b0, 1'b1, 1'b1, NOP};
    vt[1]  = '{1'b1, ADDI1,         1'b0, 1'b0, 1'b1, 1'b0, NOP};
    vt[2]  = '{1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b1, 1'b0, NOP};
    vt[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, ADDI1};
    vt[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[6]  = '{1'b1, NOP,           1'b0, 1'b0, 1'b1, 1'b1, NOP};
    vt[7]  = '{1'b1, 32'h0020_0113, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 32'h0030_0193, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0030_0193};
    vt[9]  = '{1'b1, 32'h0040_0213, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0213};
    vt[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

    do_reset();
    check_reset("reset");

    for (int i = 0; i < 11; i++) begin
      bus.i_wb_en    = vt[i].wb_en;
      bus.i_wb_rdt   = vt[i].rdt;
      bus.i_cnt_done = vt[i].done;
      bus.i_flush    = vt[i].flush;
      tick();
      idle();
      chk($sformatf("vec%0d_valid", i), bus.o_valid, vt[i].e_valid);
      chk($sformatf("vec%0d_ready", i), bus.o_ibus_ready, vt[i].e_ready);
      chk($sformatf("vec%0d_insn", i),  bus.o_insn, vt[i].e_insn);
    end

    // Random push/retire stream against an in-order scoreboard.
    for (int c = 0; c < 200; c++) begin
      w = $urandom();
      w[6:0] = 7'h13;
      bus.i_wb_rdt   = w;
      bus.i_wb_en    = ($urandom_range(0, 3) != 0);
      bus.i_cnt_done = ($urandom_range(0, 2) == 0);
      if (bus.i_cnt_done && bus.o_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got valid with %h, expected empty", bus.o_insn);
        end else begin
          chk("sb_insn", bus.o_insn, sb.pop_front());
        end
      end
      if (bus.i_wb_en && bus.o_ibus_ready) sb.push_back(w);
      tick();
    end
    idle();
    guard = 0;
    while (sb.size() != 0 && guard < 8) begin
      guard++;
      bus.i_cnt_done = 1'b1;
      if (bus.o_valid) chk("drain_insn", bus.o_insn, sb.pop_front());
      tick();
    end
    idle();
    chk("drain_left", sb.size(), 0);
    chk("drain_valid", bus.o_valid, 0);

    // Halt request while two words are queued.
    do_reset();
    push(NOP);
    push(ADDI1);
    halt = 1'b1;
    tick();
    tick();
    chk("halt_no_early_inject", bus.o_inject, 0);
    retire();
    chk("halt_inject",      bus.o_inject, 1);
    chk("halt_inject_insn", bus.o_insn, EBREAK);
    chk("halt_inject_mode", dbg_mode, 0);
    halt = 1'b0;
    retire();
    chk("halt_mode",  dbg_mode, 1);
    chk("halt_cause", cause, 3);
    chk("halt_head",  bus.o_insn, ADDI1);
    chk("halt_valid", bus.o_valid, 1);

    // Architectural ebreak, then a second one inside debug mode.
    do_reset();
    push(EBREAK);
    push(EBREAK);
    retire();
    chk("ebrk_mode",   dbg_mode, 1);
    chk("ebrk_cause",  cause, 1);
    chk("ebrk_inject", bus.o_inject, 0);
    retire();
    chk("ebrk2_mode",  dbg_mode, 1);
    chk("ebrk2_cause", cause, 1);
    chk("ebrk2_valid", bus.o_valid, 0);

    // dret with dcsr.step set.
    push(DRET);
    push(ADDI5);
    step = 1'b1;
    retire();
    chk("dret_mode", dbg_mode, 0);
    chk("dret_head", bus.o_insn, ADDI5);
    retire();
`ifdef SERV_DBG_STEP_EN
    chk("step_inject", bus.o_inject, 1);
    chk("step_insn",   bus.o_insn, EBREAK);
    retire();
    chk("step_mode",  dbg_mode, 1);
    chk("step_cause", cause, 4);
`else
    chk("nostep_inject", bus.o_inject, 0);
    chk("nostep_valid",  bus.o_valid, 0);
    chk("nostep_mode",   dbg_mode, 0);
    chk("nostep_cause",  cause, 1);
`endif
    step = 1'b0;

    // Reset while the synthetic ebreak is being presented.
    do_reset();
    halt = 1'b1;
    for (int k = 0; k < 8 && !bus.o_inject; k++) tick();
    chk("enter_seen", bus.o_inject, 1);
    rst  = 1'b1;
    halt = 1'b0;
    tick();
    rst = 1'b0;
    check_reset("rst_enter");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
